// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_mp
//  Description : Multi-read-port, dual-write-port integer register file with
//                same-cycle write-to-read bypass, a per-register busy
//                scoreboard and a sequential clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 32,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_busy,
    input  logic                         i_wr_en_a,
    input  logic [ADDR_WIDTH-1:0]        i_wr_addr_a,
    input  logic [DATA_WIDTH-1:0]        i_wr_data_a,
    input  logic                         i_wr_en_b,
    input  logic [ADDR_WIDTH-1:0]        i_wr_addr_b,
    input  logic [DATA_WIDTH-1:0]        i_wr_data_b,
    input  logic                         i_issue_en,
    input  logic [ADDR_WIDTH-1:0]        i_issue_addr,
    input  logic                         i_clear,
    output logic                         o_clear_busy
);

    localparam bit                    C_ZERO  = (ZERO_REG != 0);
    localparam bit                    C_BYP   = (BYPASS != 0);
    localparam logic [ADDR_WIDTH-1:0] C_FIRST = ADDR_WIDTH'(C_ZERO ? 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(REG_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [REG_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [REG_DEPTH];
    logic [REG_DEPTH-1:0]    busy_q,  busy_d;

    logic w_idle;
    logic w_wr_a;
    logic w_wr_b;
    logic w_iss;

    // Writes and issues only take effect while idle; x0 is hard-wired when ZERO_REG.
    assign w_idle = (state_q == S_IDLE);
    assign w_wr_a = i_wr_en_a  && !(C_ZERO && (i_wr_addr_a  == '0));
    assign w_wr_b = i_wr_en_b  && !(C_ZERO && (i_wr_addr_b  == '0));
    assign w_iss  = i_issue_en && !(C_ZERO && (i_issue_addr == '0));

    assign o_clear_busy = (state_q == S_CLEAR);

    // Clear engine next state: walk cnt from the first clearable register to the last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = C_FIRST;
                end
            end
            S_CLEAR: begin
                if (cnt_q == C_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage and scoreboard next state; B is applied after A so it wins, issue last so it wins.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (state_q == S_CLEAR) begin
            mem_d[cnt_q]  = '0;
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (w_wr_a) begin
                mem_d[i_wr_addr_a]  = i_wr_data_a;
                busy_d[i_wr_addr_a] = 1'b0;
            end
            if (w_wr_b) begin
                mem_d[i_wr_addr_b]  = i_wr_data_b;
                busy_d[i_wr_addr_b] = 1'b0;
            end
            if (w_iss) begin
                busy_d[i_issue_addr] = 1'b1;
            end
        end
    end

    // State, counter, storage and scoreboard registers with asynchronous clear.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mem_q   <= '{default: '0};
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            busy_q  <= busy_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_WIDTH-1:0] w_addr;
            logic [DATA_WIDTH-1:0] w_data;
            logic                  w_busy;

            assign w_addr = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

            // Read mux: stored value, overridden by a landing write (B over A), then by x0.
            always_comb begin
                w_data = mem_q[w_addr];
                w_busy = busy_q[w_addr];
                if (C_BYP && w_idle) begin
                    if (w_wr_a && (i_wr_addr_a == w_addr)) begin
                        w_data = i_wr_data_a;
                        w_busy = 1'b0;
                    end
                    if (w_wr_b && (i_wr_addr_b == w_addr)) begin
                        w_data = i_wr_data_b;
                        w_busy = 1'b0;
                    end
                end
                if (C_ZERO && (w_addr == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
            assign o_rd_busy[k]                          = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_mp
//  Description : Directed self-checking bench for register_file_mp
//                (defaults: 32x32, 2 read ports, bypass on, x0 hard-wired).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk;
    logic          arst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic          wr_en_a, wr_en_b;
    logic [AW-1:0] wr_addr_a, wr_addr_b;
    logic [DW-1:0] wr_data_a, wr_data_b;
    logic          issue_en;
    logic [AW-1:0] issue_addr;
    logic          clear;
    logic          clear_busy;

    int n_vec;
    int n_err;
    int cyc;

    register_file_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_DEPTH(32),
        .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_busy    (rd_busy),
        .i_wr_en_a    (wr_en_a),
        .i_wr_addr_a  (wr_addr_a),
        .i_wr_data_a  (wr_data_a),
        .i_wr_en_b    (wr_en_b),
        .i_wr_addr_b  (wr_addr_b),
        .i_wr_data_b  (wr_data_b),
        .i_issue_en   (issue_en),
        .i_issue_addr (issue_addr),
        .i_clear      (clear),
        .o_clear_busy (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rdat(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rbsy(input int p);
        return {{(DW-1){1'b0}}, rd_busy[p]};
    endfunction

    task automatic idle_inputs();
        wr_en_a = 1'b0; wr_en_b = 1'b0; issue_en = 1'b0; clear = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        arst_n = 1'b0;
        rd_addr = '0;
        wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
        issue_addr = '0;
        idle_inputs();

        // ---- 1. reset state
        #12;
        set_rd(0, 5'd5); set_rd(1, 5'd31); #1;
        chk("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
        chk("rst_rd0_data", rdat(0), 32'd0);
        chk("rst_rd1_busy", rbsy(1), 32'd0);
        #10 arst_n = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a)); set_rd(1, AW'(31 - a)); #1;
            chk("init_rd0_data", rdat(0), 32'd0);
            chk("init_rd1_data", rdat(1), 32'd0);
            chk("init_rd0_busy", rbsy(0), 32'd0);
            chk("init_rd1_busy", rbsy(1), 32'd0);
        end
        chk("init_clear_busy", {31'd0, clear_busy}, 32'd0);

        // ---- 2. basic write, x0 immunity
        wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'hDEADBEEF;
        tick();
        idle_inputs(); set_rd(1, 5'd5); #1;
        chk("wr_x5_stored", rdat(1), 32'hDEADBEEF);
        wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'h1234;
        set_rd(0, 5'd0); #1;
        chk("wr_x0_bypass", rdat(0), 32'd0);
        tick();
        idle_inputs(); #1;
        chk("wr_x0_stored", rdat(0), 32'd0);

        // ---- 3. dual write collision, B wins
        wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h33;
        tick();
        wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h11;
        wr_en_b = 1'b1; wr_addr_b = 5'd7; wr_data_b = 32'h22;
        set_rd(0, 5'd7); set_rd(1, 5'd5); #1;
        chk("coll_bypass_b", rdat(0), 32'h22);
        chk("coll_other_port", rdat(1), 32'hDEADBEEF);
        tick();
        idle_inputs(); #1;
        chk("coll_stored_b", rdat(0), 32'h22);

        // ---- 4. scoreboard
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        idle_inputs(); set_rd(0, 5'd9); #1;
        chk("issue_x9_busy", rbsy(0), 32'd1);
        wr_en_b = 1'b1; wr_addr_b = 5'd9; wr_data_b = 32'h55; #1;
        chk("wb_x9_bypass_data", rdat(0), 32'h55);
        chk("wb_x9_bypass_busy", rbsy(0), 32'd0);
        tick();
        idle_inputs(); #1;
        chk("wb_x9_busy_after", rbsy(0), 32'd0);
        chk("wb_x9_data_after", rdat(0), 32'h55);
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'h66;
        tick();
        idle_inputs(); #1;
        chk("iss_wr_same_busy", rbsy(0), 32'd1);
        chk("iss_wr_same_data", rdat(0), 32'h66);
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        idle_inputs(); set_rd(1, 5'd0); #1;
        chk("issue_x0_ignored", rbsy(1), 32'd0);

        // ---- 5. fill, mark busy, sequential clear
        for (int r = 1; r < 32; r++) begin
            wr_en_a = 1'b1; wr_addr_a = AW'(r); wr_data_a = 32'h1000 + r;
            issue_en = 1'b1; issue_addr = AW'(r);
            tick();
        end
        idle_inputs(); set_rd(0, 5'd31); set_rd(1, 5'd3); #1;
        chk("fill_x31_data", rdat(0), 32'h101F);
        chk("fill_x3_busy", rbsy(1), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc = 0;
        while (clear_busy && cyc < 100) begin
            cyc++;
            if (cyc == 10) begin
                set_rd(0, 5'd9); set_rd(1, 5'd10); #1;
                chk("mid_clear_x9", rdat(0), 32'd0);
                chk("mid_clear_x10", rdat(1), 32'h100A);
            end
            if (cyc == 20) begin
                wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'hAA;
                issue_en = 1'b1; issue_addr = 5'd5;
                clear = 1'b1;
            end
            tick();
            idle_inputs();
        end
        chk("clear_cycles", cyc, 32'd31);
        chk("clear_busy_end", {31'd0, clear_busy}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a)); #1;
            chk("post_clear_data", rdat(0), 32'd0);
            chk("post_clear_busy", rbsy(0), 32'd0);
        end
        tick();
        chk("no_restart_clear", {31'd0, clear_busy}, 32'd0);
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h77;
        tick();
        idle_inputs(); set_rd(0, 5'd3); #1;
        chk("wr_after_clear", rdat(0), 32'h77);

        // ---- 6. async reset in the middle of a clear
        wr_en_a = 1'b1; wr_addr_a = 5'd30; wr_data_a = 32'hCAFE;
        wr_en_b = 1'b1; wr_addr_b = 5'd31; wr_data_b = 32'hBEEF;
        issue_en = 1'b1; issue_addr = 5'd29;
        tick();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        set_rd(0, 5'd30); set_rd(1, 5'd29); #1;
        chk("pre_rst_x30", rdat(0), 32'hCAFE);
        chk("pre_rst_x29_busy", rbsy(1), 32'd1);
        chk("pre_rst_clear_busy", {31'd0, clear_busy}, 32'd1);
        #1 arst_n = 1'b0;
        #1;
        chk("arst_clear_busy", {31'd0, clear_busy}, 32'd0);
        chk("arst_x30", rdat(0), 32'd0);
        chk("arst_x29_busy", rbsy(1), 32'd0);
        set_rd(0, 5'd31); #1;
        chk("arst_x31", rdat(0), 32'd0);
        #1 arst_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, clear_busy}, 32'd0);
        wr_en_b = 1'b1; wr_addr_b = 5'd31; wr_data_b = 32'h9;
        tick();
        idle_inputs(); #1;
        chk("post_rst_write", rdat(0), 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
